pc_sequencer: RTL and testbench

//  Next-generation program-counter sequencer for the fetch stage. Holds the PC,

---
 rtl/pc_pkg.sv | 36 +++
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: condition codes, state type
// and the flag-based condition evaluator.
package pc_pkg;

   localparam logic [2:0] COND_NE     = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GE     = 3'b100;
   localparam logic [2:0] COND_LE     = 3'b101;
   localparam logic [2:0] COND_OV     = 3'b110;
   localparam logic [2:0] COND_UNCOND = 3'b111;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } seqState_t;

   // N is taken as the "less than" indicator, so GT/LE fold Z in explicitly.
   function automatic logic condOk(input logic [2:0] cond, input logic z,
                                   input logic n, input logic v);
      logic ok;
      unique case (cond)
         COND_NE: ok = ~z;
         COND_EQ: ok = z;
         COND_GT: ok = ~z & ~n;
         COND_LT: ok = n;
         COND_GE: ok = ~n;
         COND_LE: ok = n | z;
         COND_OV: ok = v;
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Pushing when full silently overwrites the oldest
// entry; popping when empty is ignored. Pop and push in one cycle replace the top.
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] pushData,
   output logic [ADDR_W-1:0] top,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  topPtr;
   logic [CNT_W-1:0]  count;

   logic              doPop;
   logic [PTR_W-1:0]  popPtr;
   logic [PTR_W-1:0]  pushPtr;
   logic [CNT_W-1:0]  popCnt;

   assign empty   = (count == '0);
   assign top     = mem[topPtr];
   assign doPop   = pop & ~empty;
   assign popPtr  = doPop ? topPtr - 1'b1 : topPtr;
   assign popCnt  = doPop ? count - 1'b1 : count;
   // DEPTH is a power of two, so the pointer wraps onto the oldest slot by itself.
   assign pushPtr = popPtr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         topPtr <= '0;
         count  <= '0;
      end else if (push) begin
         topPtr <= pushPtr;
         count  <= (popCnt == FULL) ? popCnt : popCnt + 1'b1;
      end else begin
         topPtr <= popPtr;
         count  <= popCnt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[pushPtr] <= pushData;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: condition evaluation, next-PC selection, stall/halt.
// Define PC_RAS_EN to add a return-address stack for call/ret.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                INC       = 2,
   parameter int                IMM_SHIFT = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              halt,
   input  logic              branch,
   input  logic              addr_src,
   input  logic [2:0]        cond,
   input  logic              flag_z,
   input  logic              flag_n,
   input  logic              flag_v,
   input  logic [ADDR_W-1:0] imm_off,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus_out,
   output logic              taken,
   output logic              halted
);

   seqState_t         state;
   logic [ADDR_W-1:0] pcReg;
   logic [ADDR_W-1:0] pcPlus;
   logic [ADDR_W-1:0] relTarget;
   logic [ADDR_W-1:0] popTarget;
   logic [ADDR_W-1:0] nextPc;
   logic              holdPc;

   assign pcPlus      = pcReg + ADDR_W'(INC);
   assign relTarget   = pcPlus + ADDR_W'(imm_off << IMM_SHIFT);
   assign pc_out      = pcReg;
   assign pc_plus_out = pcPlus;

   assign holdPc = (state == HALTED) | stall | halt;
   assign taken  = ~holdPc & branch & condOk(cond, flag_z, flag_n, flag_v);

`ifdef PC_RAS_EN
   logic [ADDR_W-1:0] rasTop;
   logic              rasEmpty;

   pc_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) uRas (
      .clk      (clk),
      .rst      (rst),
      .push     (taken & call),
      .pop      (taken & ret),
      .pushData (pcPlus),
      .top      (rasTop),
      .empty    (rasEmpty)
   );

   // An empty stack degrades a return into a plain register jump.
   assign popTarget = rasEmpty ? reg_addr : rasTop;
`else
   logic unusedCall;
   localparam int unusedRasDepth = RAS_DEPTH;

   assign unusedCall = call;
   assign popTarget  = reg_addr;
`endif

   always_comb begin
      nextPc = pcPlus;
      if (holdPc)
         nextPc = pcReg;
      else if (taken & ret)
         nextPc = popTarget;
      else if (taken & addr_src)
         nextPc = relTarget;
      else if (taken)
         nextPc = reg_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcReg  <= RESET_VEC;
         state  <= RUN;
         halted <= 1'b0;
      end else begin
         pcReg <= nextPc;
         unique case (state)
            RUN: begin
               if (halt & ~stall) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               state  <= HALTED;
               halted <= 1'b1;
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed PC values; covers the
// PC_RAS_EN stack when that macro is defined.
module tb_pc_sequencer;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, halt, branch, addr_src, call, ret;
   logic        flag_z, flag_n, flag_v;
   logic [2:0]  cond;
   logic [15:0] imm_off, reg_addr, pc_out, pc_plus_out;
   logic        taken, halted;

   int errors = 0;
   int checks = 0;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .branch(branch),
      .addr_src(addr_src), .cond(cond), .flag_z(flag_z), .flag_n(flag_n),
      .flag_v(flag_v), .imm_off(imm_off), .reg_addr(reg_addr), .call(call),
      .ret(ret), .pc_out(pc_out), .pc_plus_out(pc_plus_out), .taken(taken),
      .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; halt = 0; branch = 0; addr_src = 0; cond = COND_UNCOND;
      flag_z = 0; flag_n = 0; flag_v = 0; imm_off = '0; reg_addr = '0;
      call = 0; ret = 0;
   endtask

   task automatic jumpTo(input logic [15:0] a);
      idle();
      branch = 1; reg_addr = a;
      tick();
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc_out, 16'h0000);
      check("reset_halted", halted, 0);
      check("reset_taken", taken, 0);
      check("reset_pcplus", pc_plus_out, 16'h0002);
      rst = 0;

      // 1: async reset mid-cycle, then sequential fetch
      tick(); check("seq_a", pc_out, 16'h0002);
      tick(); check("seq_b", pc_out, 16'h0004);
      #2 rst = 1;
      #1 check("rst_async", pc_out, 16'h0000);
      #1 rst = 0;
      tick(); check("seq_1", pc_out, 16'h0002);
      tick(); check("seq_2", pc_out, 16'h0004);
      tick(); check("seq_3", pc_out, 16'h0006);

      // 2: GT relative branch, taken and not taken
      jumpTo(16'h0010);
      check("jump_reg", pc_out, 16'h0010);
      branch = 1; cond = COND_GT; addr_src = 1; imm_off = 16'h0004;
      #1 check("gt_taken", taken, 1);
      tick(); check("gt_target", pc_out, 16'h001A);
      jumpTo(16'h0010);
      branch = 1; cond = COND_GT; addr_src = 1; imm_off = 16'h0004; flag_n = 1;
      #1 check("gt_not_taken", taken, 0);
      tick(); check("gt_fallthru", pc_out, 16'h0012);

      // other condition codes, combinational only
      branch = 1; flag_n = 0;
      cond = COND_EQ; flag_z = 1; #1 check("eq_z1", taken, 1);
      cond = COND_NE;             #1 check("ne_z1", taken, 0);
      cond = COND_LE; flag_z = 0; #1 check("le_z0n0", taken, 0);
      cond = COND_GE;             #1 check("ge_n0", taken, 1);
      cond = COND_LT;             #1 check("lt_n0", taken, 0);
      cond = COND_OV; flag_v = 1; #1 check("ov_v1", taken, 1);
      idle();

      // 3: stall holds PC and suppresses the redirect
      stall = 1; branch = 1; reg_addr = 16'h0040;
      #1 check("stall_taken", taken, 0);
      tick(); check("stall_hold1", pc_out, 16'h0012);
      tick(); check("stall_hold2", pc_out, 16'h0012);
      stall = 0;
      #1 check("unstall_taken", taken, 1);
      tick(); check("unstall_redirect", pc_out, 16'h0040);
      idle();

      // 6: address wrap and negative offset
      jumpTo(16'hFFFE);
      tick(); check("wrap", pc_out, 16'h0000);
      jumpTo(16'h0010);
      branch = 1; addr_src = 1; imm_off = 16'hFFFF;
      tick(); check("neg_off", pc_out, 16'h0010);
      idle();

`ifdef PC_RAS_EN
      // 5: five calls into a depth-4 stack, then five returns
      for (int i = 1; i <= 5; i++) begin
         jumpTo(16'(i * 16'h0100));
         branch = 1; call = 1; reg_addr = 16'h1000;
         tick(); check("call_target", pc_out, 16'h1000);
         idle();
      end
      for (int i = 5; i >= 2; i--) begin
         branch = 1; ret = 1; reg_addr = 16'h0777;
         tick(); check("ret_pop", pc_out, 16'(i * 16'h0100 + 2));
         idle();
      end
      branch = 1; ret = 1; reg_addr = 16'h0777;
      tick(); check("ret_empty", pc_out, 16'h0777);
      idle();
`else
      // without the stack, call is ignored and ret is a register jump
      jumpTo(16'h0100);
      branch = 1; call = 1; reg_addr = 16'h0200;
      tick(); check("call_plain", pc_out, 16'h0200);
      idle();
      branch = 1; ret = 1; addr_src = 1; imm_off = 16'h0004; reg_addr = 16'h0300;
      tick(); check("ret_regjump", pc_out, 16'h0300);
      idle();
`endif

      // 4: halt beats a same-cycle branch, then only reset leaves HALTED
      jumpTo(16'h0020);
      halt = 1; branch = 1; reg_addr = 16'h0080;
      #1 check("halt_taken", taken, 0);
      tick(); check("halted_set", halted, 1);
      check("halt_pc", pc_out, 16'h0020);
      halt = 0;
      #1 check("halted_taken", taken, 0);
      repeat (10) tick();
      check("halt_hold_pc", pc_out, 16'h0020);
      check("halt_stays", halted, 1);
      idle();
      #2 rst = 1;
      #1 check("halt_rst_pc", pc_out, 16'h0000);
      check("halt_rst_flag", halted, 0);
      #1 rst = 0;
      tick(); check("run_after_rst", pc_out, 16'h0002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
